// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//   Serial shift datapath for an SPI master or slave. SCLK edges have already
//   been resolved into one-cycle drive (shift_stb_i) and capture (sample_stb_i)
//   strobes, so this block only tracks bit positions, drives mosi_o and
//   assembles the received word.
//
// Ports
//   pclk          : clock, all logic on the rising edge
//   preset        : synchronous active-high reset
//   ss_i          : active-low slave select; deassertion mid-frame aborts
//   start_i       : one-cycle transfer request (honoured only in IDLE, ss_i=0)
//   cpha_i        : 0 = first bit driven at load, 1 = at first shift strobe
//   lsbfe_i       : 1 = LSB first, 0 = MSB first
//   frame_len_i   : bits per frame, 0 or > DATA_W means DATA_W
//   tx_data_i     : word to transmit (low frame_len bits used)
//   shift_stb_i   : SCLK drive-edge strobe
//   sample_stb_i  : SCLK sample-edge strobe
//   miso_i        : serial data in
//   mosi_o        : serial data out (0 whenever no frame is shifting)
//   rx_data_o     : last completed received word, zero-extended
//   busy_o        : high in ACTIVE and FINISH
//   done_o        : one-cycle pulse in the FINISH cycle
//   abort_o       : one-cycle pulse after a frame is killed by ss_i
// -----------------------------------------------------------------------------
module spi_shift_engine #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = $clog2(DATA_W) + 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              ss_i,
  input  logic              start_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic [LEN_W-1:0]  frame_len_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              shift_stb_i,
  input  logic              sample_stb_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              abort_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
  localparam logic [DATA_W-1:0] BIT_ONE = DATA_W'(1);

  state_t              state;
  logic [DATA_W-1:0]   tx_shadow;
  logic [DATA_W-1:0]   rx_shadow;
  logic                cpha_q;
  logic                lsbfe_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    tx_cnt;
  logic [LEN_W-1:0]    rx_cnt;
  logic                primed;

  // Datapath helpers feeding the FSM.
  logic [LEN_W-1:0]    eff_len;
  logic [LEN_W-1:0]    start_idx;
  logic [DATA_W-1:0]   start_word;
  logic [LEN_W-1:0]    tx_cnt_next;
  logic [LEN_W-1:0]    tx_idx;
  logic [DATA_W-1:0]   tx_word;
  logic [LEN_W-1:0]    rx_idx;
  logic [DATA_W-1:0]   rx_bit_sel;
  logic [DATA_W-1:0]   rx_shadow_smp;
  logic [LEN_W-1:0]    rx_cnt_inc;
  logic [DATA_W-1:0]   len_mask;
  logic                last_sample;

  // NOTE: every always_comb output gets an unconditional value first so no
  // path can leave it holding its old value and infer a latch.
  always_comb begin
    eff_len = frame_len_i;
    if (frame_len_i == '0 || frame_len_i > LEN_MAX) begin
      eff_len = LEN_MAX;
    end

    // First bit of a new frame, using the incoming (not yet latched) settings.
    start_idx  = lsbfe_i ? '0 : (eff_len - LEN_ONE);
    start_word = tx_data_i >> start_idx;

    // The first strobe of a cpha=1 frame only primes bit 0; later strobes
    // advance, saturating on the last bit.
    tx_cnt_next = tx_cnt;
    if (!(cpha_q && !primed) && tx_cnt != (len_q - LEN_ONE)) begin
      tx_cnt_next = tx_cnt + LEN_ONE;
    end
    tx_idx  = lsbfe_q ? tx_cnt_next : (len_q - LEN_ONE - tx_cnt_next);
    tx_word = tx_shadow >> tx_idx;

    // Sampling uses the pre-shift counters, so a coincident shift is harmless.
    rx_idx        = lsbfe_q ? rx_cnt : (len_q - LEN_ONE - rx_cnt);
    rx_bit_sel    = BIT_ONE << rx_idx;
    rx_shadow_smp = miso_i ? (rx_shadow | rx_bit_sel) : (rx_shadow & ~rx_bit_sel);
    rx_cnt_inc    = rx_cnt + LEN_ONE;

    // Shift by len_q == DATA_W yields zero, so the mask becomes all ones.
    len_mask    = ~({DATA_W{1'b1}} << len_q);
    last_sample = sample_stb_i && (rx_cnt_inc == len_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before this edge regardless of order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      tx_shadow <= '0;
      rx_shadow <= '0;
      cpha_q    <= 1'b0;
      lsbfe_q   <= 1'b0;
      len_q     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      primed    <= 1'b0;
      mosi_o    <= 1'b0;
      rx_data_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      abort_o   <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      abort_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i && !ss_i) begin
            state     <= ACTIVE;
            tx_shadow <= tx_data_i;
            cpha_q    <= cpha_i;
            lsbfe_q   <= lsbfe_i;
            len_q     <= eff_len;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            primed    <= 1'b0;
            busy_o    <= 1'b1;
            mosi_o    <= cpha_i ? 1'b0 : start_word[0];
          end
        end

        ACTIVE: begin
          if (ss_i) begin
            // Killed by the controller: keep the previous rx_data_o.
            state   <= IDLE;
            busy_o  <= 1'b0;
            mosi_o  <= 1'b0;
            abort_o <= 1'b1;
          end else begin
            if (sample_stb_i) begin
              rx_shadow <= rx_shadow_smp;
              rx_cnt    <= rx_cnt_inc;
            end
            if (last_sample) begin
              // Result and done become visible together in the FINISH cycle.
              state     <= FINISH;
              mosi_o    <= 1'b0;
              rx_data_o <= rx_shadow_smp & len_mask;
              done_o    <= 1'b1;
            end else if (shift_stb_i) begin
              primed <= 1'b1;
              tx_cnt <= tx_cnt_next;
              mosi_o <= tx_word[0];
            end
          end
        end

        FINISH: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          mosi_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
